// File: rtl/cache_ctrl_pkg.sv
// Shared types and default geometry for the 4-way cache sequencing controller.
package cache_ctrl_pkg;

    localparam int CACHE_WAYS  = 4;
    localparam int CACHE_AGE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        EVAL,
        MEM_RD,
        FILL,
        CWRITE,
        MEM_WR,
        RESP
    } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// CPU-side request/response bus of the cache controller (CPU is master).
interface cache_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_done, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_done, cpu_rdata
    );
endinterface

// File: rtl/cache_lru_update.sv
// Combinational LRU helper: age update vectors for a target way and the victim way.
module cache_lru_update
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS  = CACHE_WAYS,
    parameter int AGE_W = CACHE_AGE_W,
    parameter int IDX_W = 2
) (
    input  logic [WAYS*AGE_W-1:0] ages,
    input  logic [IDX_W-1:0]      way,
    output logic [WAYS-1:0]       reset_age,
    output logic [WAYS-1:0]       increment_age,
    output logic [IDX_W-1:0]      victim
);

    logic [AGE_W-1:0] max_age;
    logic [AGE_W-1:0] tgt_age;

    // Victim depends only on ages so the target-way mux upstream has no loop.
    always_comb begin
        max_age = ages[AGE_W-1:0];
        victim  = '0;
        for (int i = 1; i < WAYS; i++) begin
            if (ages[i*AGE_W +: AGE_W] > max_age) begin
                max_age = ages[i*AGE_W +: AGE_W];
                victim  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        reset_age     = '0;
        increment_age = '0;
        tgt_age       = ages[way*AGE_W +: AGE_W];
        for (int i = 0; i < WAYS; i++) begin
            if (i == int'(way))
                reset_age[i] = 1'b1;
            else if (ages[i*AGE_W +: AGE_W] < tgt_age)
                increment_age[i] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Write-through / write-allocate sequencing controller for a 4-way cache.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter int WAYS   = CACHE_WAYS,
    parameter int AGE_W  = CACHE_AGE_W
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef CACHE_CTRL_STATS_EN
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt,
`endif
    cache_controller_if.slave      cpu,
    output logic [ADDR_W-1:0]      address_word,
    output logic                   try_read,
    output logic                   try_write,
    output logic [DATA_W-1:0]      write_data,
    output logic [WAYS-1:0]        reset_age,
    output logic [WAYS-1:0]        increment_age,
    input  logic [DATA_W-1:0]      data,
    input  logic [WAYS*AGE_W-1:0]  ages,
    input  logic                   hit_miss,
    input  logic [WAYS-1:0]        hit_miss_set,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]     addr_p0;
    logic                  we_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic                  hit_p1;
    logic [IDX_W-1:0]      hit_way_p1;
    logic [WAYS*AGE_W-1:0] ages_p1;
    logic [DATA_W-1:0]     rdata_p1;

    logic [IDX_W-1:0]      hit_way, victim, tgt_way;
    logic [WAYS*AGE_W-1:0] lru_ages;
    logic [WAYS-1:0]       lru_reset, lru_inc;
    logic                  upd_en;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [WAYS-1:0] v);
        lowest_set = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (v[i]) lowest_set = IDX_W'(i);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu.cpu_req) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = EVAL;
            EVAL: begin
                if (we_p0)         state_nxt = CWRITE;
                else if (hit_miss) state_nxt = RESP;
                else               state_nxt = MEM_RD;
            end
            MEM_RD:  if (mem_ack) state_nxt = FILL;
            FILL:    state_nxt = RESP;
            CWRITE:  state_nxt = MEM_WR;
            MEM_WR:  if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch at accept, lookup results sampled in EVAL for CWRITE/FILL.
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu.cpu_req) begin
            addr_p0  <= cpu.cpu_addr;
            we_p0    <= cpu.cpu_we;
            wdata_p0 <= cpu.cpu_wdata;
        end
        if (state == EVAL) begin
            hit_p1     <= hit_miss;
            hit_way_p1 <= hit_way;
            ages_p1    <= ages;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_p1 <= '0;
        else if (state == EVAL && !we_p0 && hit_miss)
            rdata_p1 <= data;
        else if (state == MEM_RD && mem_ack)
            rdata_p1 <= mem_rdata;
    end

    assign hit_way  = lowest_set(hit_miss_set);
    assign lru_ages = (state == EVAL) ? ages : ages_p1;

    always_comb begin
        tgt_way = victim;
        if (state == EVAL)
            tgt_way = hit_way;
        else if (state == CWRITE && hit_p1)
            tgt_way = hit_way_p1;
    end

    cache_lru_update #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_lru (
        .ages          (lru_ages),
        .way           (tgt_way),
        .reset_age     (lru_reset),
        .increment_age (lru_inc),
        .victim        (victim)
    );

    always_comb begin
        cpu.cpu_ready = (state == IDLE);
        cpu.cpu_done  = (state == RESP);
        cpu.cpu_rdata = rdata_p1;
        try_read      = (state == LOOKUP);
        try_write     = (state == FILL) || (state == CWRITE);
        write_data    = '0;
        if (state == FILL)
            write_data = rdata_p1;
        else if (state == CWRITE)
            write_data = wdata_p0;
        upd_en        = ((state == EVAL) && !we_p0 && hit_miss) ||
                        (state == FILL) || (state == CWRITE);
        reset_age     = upd_en ? lru_reset : '0;
        increment_age = upd_en ? lru_inc   : '0;
        mem_req       = (state == MEM_RD) || (state == MEM_WR);
        mem_we        = (state == MEM_WR);
        mem_wdata     = (state == MEM_WR) ? wdata_p0 : '0;
        address_word  = (state != IDLE) ? addr_p0 : '0;
        mem_addr      = (state != IDLE) ? addr_p0 : '0;
    end

`ifdef CACHE_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == EVAL) begin
            if (hit_miss) hit_cnt  <= sat_inc(hit_cnt);
            else          miss_cnt <= sat_inc(miss_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomised bench for cache_controller with a per-cycle expected-output trace model.
module tb_cache_controller;

    localparam int AW = 32;
    localparam int DW = 8;

    typedef struct packed {
        logic          ready;
        logic          done;
        logic          try_read;
        logic          try_write;
        logic [7:0]    wdat;
        logic [3:0]    rst_age;
        logic [3:0]    inc_age;
        logic          mem_req;
        logic          mem_we;
        logic [7:0]    mem_wdata;
        logic [31:0]   addr;
        logic [31:0]   maddr;
    } obs_t;

    typedef struct {
        obs_t       o;
        logic       chk;
        logic [7:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_controller_if #(.ADDR_W(AW), .DATA_W(DW)) cpu ();

    logic [AW-1:0] address_word, mem_addr;
    logic          try_read, try_write, hit_miss, mem_req, mem_we, mem_ack;
    logic [DW-1:0] write_data, data, mem_wdata, mem_rdata;
    logic [3:0]    reset_age, increment_age, hit_miss_set;
    logic [7:0]    ages;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0]   hit_cnt, miss_cnt;
`endif

    cache_controller dut (
        .clk           (clk),
        .rst           (rst),
`ifdef CACHE_CTRL_STATS_EN
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
`endif
        .cpu           (cpu.slave),
        .address_word  (address_word),
        .try_read      (try_read),
        .try_write     (try_write),
        .write_data    (write_data),
        .reset_age     (reset_age),
        .increment_age (increment_age),
        .data          (data),
        .ages          (ages),
        .hit_miss      (hit_miss),
        .hit_miss_set  (hit_miss_set),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    int   cur_lat = 1;
    int   mcnt = 0;
    int   hits = 0;
    int   misses = 0;
    logic chk_en = 1'b0;
    logic [7:0] cur_mrdata = '0;
    logic [7:0] last_rdata = '0, last_wr_data = '0, last_mem_wdata = '0;
    logic [3:0] last_upd_rst = '0, last_upd_inc = '0;
    exp_t exp_q[$];

    function automatic int age_of(input logic [7:0] ag, input int i);
        return int'(ag[i*2 +: 2]);
    endfunction

    function automatic int hit_way_of(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic int victim_of(input logic [7:0] ag);
        int mx = 0;
        for (int i = 0; i < 4; i++) if (age_of(ag, i) > mx) mx = age_of(ag, i);
        for (int i = 0; i < 4; i++) if (age_of(ag, i) == mx) return i;
        return 0;
    endfunction

    function automatic void age_upd(input logic [7:0] ag, input int w,
                                    output logic [3:0] r, output logic [3:0] inc);
        r   = 4'b0001 << w;
        inc = '0;
        for (int i = 0; i < 4; i++)
            if (i != w && age_of(ag, i) < age_of(ag, w)) inc[i] = 1'b1;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.ready     = cpu.cpu_ready;
        o.done      = cpu.cpu_done;
        o.try_read  = try_read;
        o.try_write = try_write;
        o.wdat      = write_data;
        o.rst_age   = reset_age;
        o.inc_age   = increment_age;
        o.mem_req   = mem_req;
        o.mem_we    = mem_we;
        o.mem_wdata = mem_wdata;
        o.addr      = address_word;
        o.maddr     = mem_addr;
        return o;
    endfunction

    function automatic void push(input obs_t o, input logic c, input logic [7:0] r);
        exp_t e;
        e.o = o; e.chk = c; e.rd = r;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the expected trace (idle when the trace is empty).
    always @(negedge clk) begin
        obs_t act;
        exp_t e;
        cyc++;
        if (chk_en) begin
            act = get_obs();
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin e.o = idle_obs(); e.chk = 1'b0; e.rd = '0; end
            n_cmp++;
            if (act !== e.o || (e.chk && cpu.cpu_rdata !== e.rd)) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got %h rdata %h, expected %h rdata %h (rdata checked=%0d)",
                         cyc, act, cpu.cpu_rdata, e.o, e.rd, e.chk);
            end
            if (act.done) begin last_rdata = cpu.cpu_rdata; done_cyc = cyc; end
            if (act.try_write) last_wr_data = act.wdat;
            if (act.mem_we) last_mem_wdata = act.mem_wdata;
            if (act.rst_age != 0) begin last_upd_rst = act.rst_age; last_upd_inc = act.inc_age; end
        end
    end

    // Memory responder: acks after cur_lat request cycles, random stray acks when idle.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mcnt++;
                mem_ack   = (mcnt == cur_lat);
                mem_rdata = (mcnt == cur_lat) ? cur_mrdata : 8'($urandom);
            end else begin
                mcnt      = 0;
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = 8'($urandom);
            end
        end
    end

    task automatic run_txn(input logic we, input logic [31:0] a, input logic [7:0] wd,
                           input logic hit, input logic [3:0] hs, input logic [7:0] d,
                           input logic [7:0] ag, input int lat, input logic [7:0] mrd);
        obs_t base, t;
        logic [7:0] rd;
        int k;
        @(negedge clk);
        cur_lat = lat; cur_mrdata = mrd;
        cpu.cpu_req = 1'b1; cpu.cpu_we = we; cpu.cpu_addr = a; cpu.cpu_wdata = wd;
        hit_miss = hit; hit_miss_set = hs; data = d; ages = ag;
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (hit) hits++; else misses++;
        base = '0; base.addr = a; base.maddr = a;
        t = base; t.try_read = 1'b1; push(t, 1'b0, '0);
        t = base;
        if (!we && hit) age_upd(ag, hit_way_of(hs), t.rst_age, t.inc_age);
        push(t, 1'b0, '0);
        rd = '0;
        if (!we && hit) begin
            rd = d;
        end else if (!we) begin
            for (int i = 0; i < lat; i++) begin t = base; t.mem_req = 1'b1; push(t, 1'b0, '0); end
            t = base; t.try_write = 1'b1; t.wdat = mrd;
            age_upd(ag, victim_of(ag), t.rst_age, t.inc_age);
            push(t, 1'b0, '0);
            rd = mrd;
        end else begin
            t = base; t.try_write = 1'b1; t.wdat = wd;
            age_upd(ag, hit ? hit_way_of(hs) : victim_of(ag), t.rst_age, t.inc_age);
            push(t, 1'b0, '0);
            for (int i = 0; i < lat; i++) begin
                t = base; t.mem_req = 1'b1; t.mem_we = 1'b1; t.mem_wdata = wd; push(t, 1'b0, '0);
            end
        end
        t = base; t.done = 1'b1; push(t, !we, rd);
        // Busy-time requests with junk fields must be ignored.
        cpu.cpu_req = 1'($urandom); cpu.cpu_we = 1'($urandom);
        cpu.cpu_addr = $urandom; cpu.cpu_wdata = 8'($urandom);
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin @(posedge clk); k++; end
        #1;
        cpu.cpu_req = 1'b0;
        if (exp_q.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL txn_timeout: %0d expected cycles left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int k, busy_seen, done_seen;
        rst = 1'b1;
        cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_addr = '0; cpu.cpu_wdata = '0;
        hit_miss = 1'b0; hit_miss_set = '0; data = '0; ages = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 128'(get_obs()), 128'(idle_obs()));
        check("reset_rdata", 128'(cpu.cpu_rdata), 128'(8'h00));
        rst = 1'b0;
        chk_en = 1'b1;

        run_txn(1'b0, 32'h1000_0040, 8'h00, 1'b1, 4'b0100, 8'h5A, 8'b11_10_01_00, 1, 8'h00);
        check("hit_rdata", 128'(last_rdata), 128'(8'h5A));
        check("hit_latency", 128'(done_cyc - acc_cyc), 128'(3));
        check("hit_reset_age", 128'(last_upd_rst), 128'(4'b0100));
        check("hit_inc_age", 128'(last_upd_inc), 128'(4'b0011));

        run_txn(1'b0, 32'h2000_0080, 8'h00, 1'b0, 4'b0000, 8'h11, 8'b00_11_10_01, 2, 8'hC3);
        check("miss_fill_data", 128'(last_wr_data), 128'(8'hC3));
        check("miss_reset_age", 128'(last_upd_rst), 128'(4'b0100));
        check("miss_inc_age", 128'(last_upd_inc), 128'(4'b1011));
        check("miss_rdata", 128'(last_rdata), 128'(8'hC3));

        run_txn(1'b1, 32'h3000_00C0, 8'h77, 1'b1, 4'b0001, 8'h00, 8'b01_10_11_00, 3, 8'h00);
        check("write_cache_data", 128'(last_wr_data), 128'(8'h77));
        check("write_mem_data", 128'(last_mem_wdata), 128'(8'h77));
        check("write_reset_age", 128'(last_upd_rst), 128'(4'b0001));

        run_txn(1'b0, 32'h4000_0100, 8'h00, 1'b0, 4'b0000, 8'h00, 8'hFF, 1, 8'h3C);
        check("tie_victim", 128'(last_upd_rst), 128'(4'b0001));

        run_txn(1'b0, 32'h5000_0140, 8'h00, 1'b1, 4'b1010, 8'h66, 8'b00_01_10_11, 1, 8'h00);
        check("multi_hit_way", 128'(last_upd_rst), 128'(4'b0010));

        for (int n = 0; n < 150; n++) begin
            logic       r_hit;
            logic [3:0] r_hs;
            r_hit = 1'($urandom);
            r_hs  = r_hit ? 4'($urandom_range(1, 15)) : 4'($urandom);
            run_txn(1'($urandom), $urandom, 8'($urandom), r_hit, r_hs, 8'($urandom),
                    8'($urandom), int'($urandom_range(1, 4)), 8'($urandom));
        end

`ifdef CACHE_CTRL_STATS_EN
        check("stat_hit_cnt", 128'(hit_cnt), 128'(hits));
        check("stat_miss_cnt", 128'(miss_cnt), 128'(misses));
`endif

        // Reset in the middle of a memory read.
        chk_en = 1'b0;
        @(negedge clk);
        cur_lat = 1000;
        cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_addr = 32'h6000_0000;
        hit_miss = 1'b0;
        @(posedge clk); #1;
        k = 0;
        while (!mem_req && k < 20) begin @(posedge clk); #1; k++; end
        check("mem_req_before_rst", 128'(mem_req), 128'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_async_mem_req", 128'(mem_req), 128'(0));
        check("rst_async_try", 128'({try_read, try_write}), 128'(2'b00));
        check("rst_async_ready", 128'(cpu.cpu_ready), 128'(1));
        @(negedge clk);
        cpu.cpu_req = 1'b0;
        rst = 1'b0;
        busy_seen = 0; done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu.cpu_done) done_seen++;
            if (!cpu.cpu_ready) busy_seen++;
        end
        check("rst_no_done", 128'(done_seen), 128'(0));
        check("rst_not_accepted", 128'(busy_seen), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
